remap_line_coord_gen: RTL

//  Pixel-clock stage directly upstream of the DDR3 remap pixel writer.

---
 rtl/remap_line_coord_gen.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/remap_line_coord_gen.sv
// Tags each remapped pixel with its tile-row gray flag and emits one write-coordinate
// word per line. Counters walk pixel, line, tile column, tile row in tile-raster order.
module remap_line_coord_gen #(
    parameter int unsigned LINE_PIX       = 32,
    parameter int unsigned TILE_H         = 16,
    parameter int unsigned TILES_X        = 30,
    parameter int unsigned TILES_Y        = 30,
    parameter int unsigned GRAY_ROW_LO    = 15,
    parameter int unsigned GRAY_ROW_HI    = 30,
    parameter bit          LAST_COL_SHORT = 1'b0
) (
    input  logic        pclk,
    input  logic        pclk_reset_n,
    input  logic [15:0] in_pixel,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    input  logic        fifo_almost_full,
    output logic [16:0] pixel_data,
    output logic        pixel_valid,
    output logic [34:0] coords_out,
    output logic        coords_out_valid,
    output logic        frame_done,
    output logic        sync_err
);

    localparam int unsigned PX_W = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
    localparam int unsigned LN_W = (TILE_H   > 1) ? $clog2(TILE_H)   : 1;
    localparam int unsigned TC_W = (TILES_X  > 1) ? $clog2(TILES_X)  : 1;
    localparam int unsigned TR_W = (TILES_Y  > 1) ? $clog2(TILES_Y)  : 1;
    localparam int unsigned CW   = 35;

    logic [PX_W-1:0] px_q,   px_d;
    logic [LN_W-1:0] line_q, line_d;
    logic [TC_W-1:0] tcol_q, tcol_d;
    logic [TR_W-1:0] trow_q, trow_d;

    logic [16:0]   pixel_data_q,  pixel_data_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [CW-1:0] coords_q,      coords_d;
    logic          coords_vld_q,  coords_vld_d;
    logic          frame_done_q,  frame_done_d;
    logic          sync_err_q,    sync_err_d;

    logic            xfer;
    logic            cnt_nz;
    logic [PX_W-1:0] px_e;
    logic [LN_W-1:0] line_e;
    logic [TC_W-1:0] tcol_e;
    logic [TR_W-1:0] trow_e;
    logic            gray;
    logic            short_line;
    logic [PX_W-1:0] px_last;
    logic            last_px, last_line, last_col, last_row;
    logic [15:0]     coord_x, coord_y;

    assign in_ready = pclk_reset_n && !fifo_almost_full;

    // Position of the current pixel; an accepted in_sof always restarts at the frame origin.
    always_comb begin
        xfer   = in_valid && in_ready;
        cnt_nz = (|px_q) || (|line_q) || (|tcol_q) || (|trow_q);
        px_e   = in_sof ? '0 : px_q;
        line_e = in_sof ? '0 : line_q;
        tcol_e = in_sof ? '0 : tcol_q;
        trow_e = in_sof ? '0 : trow_q;

        gray       = (32'(trow_e) >= GRAY_ROW_LO) && (32'(trow_e) < GRAY_ROW_HI);
        short_line = LAST_COL_SHORT && (tcol_e == TC_W'(TILES_X - 1));
        px_last    = short_line ? PX_W'(LINE_PIX / 2 - 1) : PX_W'(LINE_PIX - 1);

        last_px   = (px_e   == px_last);
        last_line = (line_e == LN_W'(TILE_H - 1));
        last_col  = (tcol_e == TC_W'(TILES_X - 1));
        last_row  = (trow_e == TR_W'(TILES_Y - 1));

        coord_x = 16'(tcol_e) * 16'(LINE_PIX);
        coord_y = 16'(trow_e) * 16'(TILE_H) + 16'(line_e);
    end

    // Counter walk and registered outputs for the next cycle.
    always_comb begin
        px_d          = px_q;
        line_d        = line_q;
        tcol_d        = tcol_q;
        trow_d        = trow_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        coords_d      = coords_q;
        coords_vld_d  = 1'b0;
        frame_done_d  = 1'b0;
        sync_err_d    = sync_err_q;

        if (xfer) begin
            pixel_valid_d = 1'b1;
            pixel_data_d  = {gray, in_pixel};
            if (in_sof && cnt_nz) begin
                sync_err_d = 1'b1;
            end
            if (px_e == '0) begin
                coords_vld_d = 1'b1;
                coords_d     = {last_line && last_col && last_row, gray, short_line,
                                coord_y, coord_x};
            end

            px_d   = px_e + PX_W'(1);
            line_d = line_e;
            tcol_d = tcol_e;
            trow_d = trow_e;
            if (last_px) begin
                px_d   = '0;
                line_d = line_e + LN_W'(1);
                if (last_line) begin
                    line_d = '0;
                    tcol_d = tcol_e + TC_W'(1);
                    if (last_col) begin
                        tcol_d = '0;
                        trow_d = trow_e + TR_W'(1);
                        if (last_row) begin
                            trow_d       = '0;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge pclk_reset_n) begin
        if (!pclk_reset_n) begin
            px_q          <= '0;
            line_q        <= '0;
            tcol_q        <= '0;
            trow_q        <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            coords_q      <= '0;
            coords_vld_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            px_q          <= px_d;
            line_q        <= line_d;
            tcol_q        <= tcol_d;
            trow_q        <= trow_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            coords_q      <= coords_d;
            coords_vld_q  <= coords_vld_d;
            frame_done_q  <= frame_done_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign pixel_data       = pixel_data_q;
    assign pixel_valid      = pixel_valid_q;
    assign coords_out       = coords_q;
    assign coords_out_valid = coords_vld_q;
    assign frame_done       = frame_done_q;
    assign sync_err         = sync_err_q;

endmodule
